// File: rtl/multiplier_l2_pkg.sv
// Shared micro-op encoding plus the RV32M multiply operand/result helpers.
// Combinational only; no storage or handshake of its own.
package multiplier_l2_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ADD    = 4'd1,
    OP_SUB    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_XOR    = 4'd5,
    OP_MUL    = 4'd8,
    OP_MULH   = 4'd9,
    OP_MULHSU = 4'd10,
    OP_MULHU  = 4'd11
  } rv_uop;

  function automatic logic op1_is_signed(rv_uop uop);
    return uop != OP_MULHU;
  endfunction

  function automatic logic op2_is_signed(rv_uop uop);
    return (uop == OP_MUL) || (uop == OP_MULH);
  endfunction

  function automatic logic [31:0] sel_result(rv_uop uop, logic [63:0] product);
    case (uop)
      OP_MUL:                       return product[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return product[63:32];
      default:                      return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/multiplier_l2_if.sv
// Issue-side (D->X) and writeback-side (X->W) valid/ready bundles.
// Transfer happens on any edge where val & rdy are both high.
interface multiplier_l2_dx_if #(parameter int p_seq_num_bits = 8);
  import multiplier_l2_pkg::*;

  logic                      val;
  logic                      rdy;
  logic [31:0]               pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [31:0]               op1;
  logic [31:0]               op2;
  logic [4:0]                waddr;
  rv_uop                     uop;

  modport master (output val, pc, seq_num, op1, op2, waddr, uop, input rdy);
  modport slave  (input val, pc, seq_num, op1, op2, waddr, uop, output rdy);
endinterface

interface multiplier_l2_xw_if #(parameter int p_seq_num_bits = 8);
  logic                      val;
  logic                      rdy;
  logic [31:0]               pc;
  logic [p_seq_num_bits-1:0] seq_num;
  logic [4:0]                waddr;
  logic [31:0]               wdata;
  logic                      wen;

  modport master (output val, pc, seq_num, waddr, wdata, wen, input rdy);
  modport slave  (input val, pc, seq_num, waddr, wdata, wen, output rdy);
endinterface

// File: rtl/multiplier_l2_mul_signext_33x33.sv
// Combinational 33x33 signed multiply with per-operand sign/zero extension.
// Returns the low 64 bits of the 66-bit product, which is all RV32M ever needs.
module mul_signext_33x33 (
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic        i_op1_signed,
  input  logic        i_op2_signed,
  output logic [63:0] o_product
);

  logic [32:0]        w_a33;
  logic [32:0]        w_b33;
  logic signed [63:0] w_a;
  logic signed [63:0] w_b;

  assign w_a33 = {i_op1_signed & i_op1[31], i_op1};
  assign w_b33 = {i_op2_signed & i_op2[31], i_op2};

  // Bits [65:64] are never kept, so a 64-bit product of the sign-extended
  // 33-bit operands is bit-identical to the low 64 bits of the 66-bit one.
  assign w_a = {{31{w_a33[32]}}, w_a33};
  assign w_b = {{31{w_b33[32]}}, w_b33};

  assign o_product = w_a * w_b;

endmodule

// File: rtl/multiplier_l2.sv
// Pipelined RV32M multiply unit: result on W p_stages-1 cycles after D transfer.
// Whole pipeline freezes while W holds a result that writeback refuses.
module multiplier_l2
  import multiplier_l2_pkg::*;
#(
  parameter int p_stages = 2
) (
  input  logic                clk,
  input  logic                rst,
  multiplier_l2_dx_if.slave   D,
  multiplier_l2_xw_if.master  W
);

  localparam int p_seq_num_bits = D.p_seq_num_bits;

  // Stage 0 payload is {op1, op2}; every later stage carries the product.
  typedef struct packed {
    logic                      val;
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    rv_uop                     uop;
    logic [63:0]               payload;
  } stage_t;

  logic        w_stall;
  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [63:0] w_product;
  logic [63:0] w_last_product;
  stage_t      w_last;

  assign w_stall = W.val & ~W.rdy;
  assign D.rdy   = ~w_stall;

  for (genvar k = 0; k < p_stages; k++) begin : g_stage
    stage_t r_st;
    stage_t w_nxt;

    if (k == 0) begin : g_in
      always_comb begin
        w_nxt         = '0;
        w_nxt.val     = D.val & D.rdy;
        w_nxt.pc      = D.pc;
        w_nxt.seq_num = D.seq_num;
        w_nxt.waddr   = D.waddr;
        w_nxt.uop     = D.uop;
        w_nxt.payload = {D.op1, D.op2};
      end
    end else begin : g_fwd
      localparam bit FIRST_PRODUCT = (k == 1);
      always_comb begin
        w_nxt         = g_stage[k-1].r_st;
        w_nxt.payload = FIRST_PRODUCT ? w_product : g_stage[k-1].r_st.payload;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_st.val <= 1'b0;
      end else if (!w_stall) begin
        r_st <= w_nxt;
      end
    end
  end

  assign {w_op1, w_op2} = g_stage[0].r_st.payload;

  mul_signext_33x33 u_mul (
    .i_op1        (w_op1),
    .i_op2        (w_op2),
    .i_op1_signed (op1_is_signed(g_stage[0].r_st.uop)),
    .i_op2_signed (op2_is_signed(g_stage[0].r_st.uop)),
    .o_product    (w_product)
  );

  // A single-stage pipe selects straight from the multiplier output.
  assign w_last         = g_stage[p_stages-1].r_st;
  assign w_last_product = (p_stages == 1) ? w_product : w_last.payload;

  assign W.val     = w_last.val;
  assign W.pc      = w_last.pc;
  assign W.seq_num = w_last.seq_num;
  assign W.waddr   = w_last.waddr;
  assign W.wdata   = sel_result(w_last.uop, w_last_product);
  assign W.wen     = 1'b1;

endmodule

// File: tb/tb_multiplier_l2.sv
// Directed checks on a 2-stage unit plus a random scoreboard over depths 1..4.
module tb_multiplier_l2;
  import multiplier_l2_pkg::*;

  localparam int SEQ_W = 8;

  typedef struct {
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             d_val;
  logic [31:0]      d_pc;
  logic [SEQ_W-1:0] d_seq;
  logic [31:0]      d_op1;
  logic [31:0]      d_op2;
  logic [4:0]       d_waddr;
  rv_uop            d_uop;
  logic             w_rdy;
  logic             sb_en = 1'b0;
  int               ncyc  = 0;
  int               n_pass  = 0;
  int               n_total = 0;

  always #5 clk = ~clk;
  always @(negedge clk) ncyc <= ncyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_mul(rv_uop u, logic [31:0] a, logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      za = longint'({32'h0, a});
    longint      zb = longint'({32'h0, b});
    logic [63:0] p;
    case (u)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * zb; return p[63:32]; end
      OP_MULHU:  begin p = za * zb; return p[63:32]; end
      default:   return 32'h0;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int P = g + 1;
    multiplier_l2_dx_if #(.p_seq_num_bits(SEQ_W)) dx ();
    multiplier_l2_xw_if #(.p_seq_num_bits(SEQ_W)) xw ();
    exp_t q[$];

    assign dx.val     = d_val;
    assign dx.pc      = d_pc;
    assign dx.seq_num = d_seq;
    assign dx.op1     = d_op1;
    assign dx.op2     = d_op2;
    assign dx.waddr   = d_waddr;
    assign dx.uop     = d_uop;
    assign xw.rdy     = w_rdy;

    multiplier_l2 #(.p_stages(P)) u_dut (
      .clk (clk),
      .rst (rst),
      .D   (dx),
      .W   (xw)
    );

    // Transfer sampled before edge N appears from the negedge after edge N+P-1.
    always @(negedge clk) begin
      if (sb_en) begin
        if (xw.val) begin
          if (q.size() == 0) begin
            check($sformatf("rand_p%0d_extra", P), xw.val, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("rand_p%0d", P), {xw.wdata, xw.seq_num, ncyc[23:0]},
                  {e.data, e.seq, e.due[23:0]});
          end
        end else if (q.size() != 0 && q[0].due <= ncyc) begin
          check($sformatf("rand_p%0d_late", P), xw.val, 1);
          void'(q.pop_front());
        end
        if (dx.val && dx.rdy)
          q.push_back('{ref_mul(dx.uop, dx.op1, dx.op2), dx.seq_num, ncyc + P});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input rv_uop u, input logic [31:0] a,
                       input logic [31:0] b, input logic [SEQ_W-1:0] s);
    d_val   = v;
    d_uop   = u;
    d_op1   = a;
    d_op2   = b;
    d_seq   = s;
    d_pc    = 32'h1000 + {22'h0, s, 2'b00};
    d_waddr = s[4:0];
  endtask

  task automatic single(input string tag, input rv_uop u, input logic [31:0] a,
                        input logic [31:0] b, input logic [SEQ_W-1:0] s,
                        input logic [31:0] exp);
    drive(1'b1, u, a, b, s);
    step();
    d_val = 1'b0;
    check({tag, "_val_early"}, g_dut[1].xw.val, 0);
    step();
    check({tag, "_val"}, g_dut[1].xw.val, 1);
    check({tag, "_data"}, {g_dut[1].xw.wdata, g_dut[1].xw.seq_num}, {exp, s});
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int issued;
    rst = 1'b1;
    w_rdy = 1'b1;
    drive(1'b0, OP_NOP, 0, 0, 0);
    repeat (3) step();
    check("reset_wval", g_dut[1].xw.val, 0);
    check("reset_drdy", g_dut[1].dx.rdy, 1);
    rst = 1'b0;
    step();

    single("mul_7x6", OP_MUL, 7, 6, 3, 32'h0000_002A);
    check("mul_7x6_wen", g_dut[1].xw.wen, 1);
    check("mul_7x6_pc", {g_dut[1].xw.pc, 27'h0, g_dut[1].xw.waddr}, {32'h100C, 32'd3});
    step();
    check("mul_7x6_gone", g_dut[1].xw.val, 0);

    single("mulh_m1x2",   OP_MULH,   32'hFFFF_FFFF, 32'h2,          4, 32'hFFFF_FFFF);
    single("mulhu_m1x2",  OP_MULHU,  32'hFFFF_FFFF, 32'h2,          5, 32'h0000_0001);
    single("mulhsu_m1x2", OP_MULHSU, 32'hFFFF_FFFF, 32'h2,          6, 32'hFFFF_FFFF);
    single("mulh_min2",   OP_MULH,   32'h8000_0000, 32'h8000_0000,  7, 32'h4000_0000);
    single("mulhsu_minx", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF,  8, 32'h8000_0000);
    single("mulhu_max2",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  9, 32'hFFFF_FFFE);
    single("other_uop",   OP_ADD,    32'h5,         32'h6,         10, 32'h0);
    check("other_uop_wen", g_dut[1].xw.wen, 1);
    step();

    begin
      logic [31:0] a_t[4] = '{32'd3, 32'd100, 32'hFFFF_FFFE, 32'h8000_0000};
      logic [31:0] b_t[4] = '{32'd5, 32'd100, 32'd3,         32'd4};
      rv_uop       u_t[4] = '{OP_MUL, OP_MUL, OP_MUL, OP_MULHU};
      logic [31:0] e_t[4] = '{32'd15, 32'd10000, 32'hFFFF_FFFA, 32'd2};
      drive(1'b1, u_t[0], a_t[0], b_t[0], 8'd40);
      for (int i = 0; i < 5; i++) begin
        step();
        check($sformatf("b2b_drdy%0d", i), g_dut[1].dx.rdy, 1);
        if (i >= 1)
          check($sformatf("b2b_out%0d", i - 1),
                {g_dut[1].xw.val, g_dut[1].xw.wdata, g_dut[1].xw.seq_num},
                {1'b1, e_t[i-1], 8'(40 + i - 1)});
        if (i + 1 < 4) drive(1'b1, u_t[i+1], a_t[i+1], b_t[i+1], 8'(40 + i + 1));
        else           d_val = 1'b0;
      end
      step();
      check("b2b_gone", g_dut[1].xw.val, 0);
    end

    drive(1'b1, OP_MUL, 11, 11, 20);
    step();
    drive(1'b1, OP_MUL, 12, 12, 21);
    step();
    w_rdy = 1'b0;
    drive(1'b1, OP_MUL, 13, 13, 22);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_drdy%0d", i), g_dut[1].dx.rdy, 0);
      check($sformatf("bp_hold%0d", i),
            {g_dut[1].xw.val, g_dut[1].xw.wdata, g_dut[1].xw.seq_num}, {1'b1, 32'd121, 8'd20});
      step();
    end
    check("bp_hold_end", {g_dut[1].xw.val, g_dut[1].xw.wdata, g_dut[1].xw.seq_num},
          {1'b1, 32'd121, 8'd20});
    w_rdy = 1'b1;
    #1;
    check("bp_release_drdy", g_dut[1].dx.rdy, 1);
    step();
    d_val = 1'b0;
    check("bp_b", {g_dut[1].xw.val, g_dut[1].xw.wdata, g_dut[1].xw.seq_num},
          {1'b1, 32'd144, 8'd21});
    step();
    check("bp_c", {g_dut[1].xw.val, g_dut[1].xw.wdata, g_dut[1].xw.seq_num},
          {1'b1, 32'd169, 8'd22});
    step();
    check("bp_empty", g_dut[1].xw.val, 0);

    drive(1'b1, OP_MUL, 2, 3, 30);
    step();
    drive(1'b1, OP_MUL, 4, 5, 31);
    step();
    check("rst_pre_wval", g_dut[1].xw.val, 1);
    d_val = 1'b0;
    rst = 1'b1;
    step();
    check("rst_mid_wval", g_dut[1].xw.val, 0);
    check("rst_mid_drdy", g_dut[1].dx.rdy, 1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_no_stale%0d", i), g_dut[1].xw.val, 0);
    end

    sb_en  = 1'b1;
    issued = 0;
    while (issued < 1000) begin
      case ($urandom_range(0, 3))
        0:       d_uop = OP_MUL;
        1:       d_uop = OP_MULH;
        2:       d_uop = OP_MULHSU;
        default: d_uop = OP_MULHU;
      endcase
      drive($urandom_range(0, 3) != 0, d_uop, pick_val(), pick_val(), 8'(issued));
      step();
      if (d_val) issued++;
    end
    d_val = 1'b0;
    repeat (8) step();
    sb_en = 1'b0;
    check("drain_p1", g_dut[0].q.size(), 0);
    check("drain_p2", g_dut[1].q.size(), 0);
    check("drain_p3", g_dut[2].q.size(), 0);
    check("drain_p4", g_dut[3].q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
